// File: rtl/ram_writer_pkg.sv
// ram_writer_pkg
//   Shared types and defaults for the sequential RAM writer.
//   - state_e        : writer mode (IDLE = append, CLEAR = bulk fill)
//   - DEFAULT_ADDR_W : default RAM address width
//   - DEPTH          : default RAM depth (2**DEFAULT_ADDR_W)
package ram_writer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned DEPTH          = 2 ** DEFAULT_ADDR_W;

endpackage

// File: rtl/wr_ptr_counter.sv
// wr_ptr_counter
//   ADDR_W-bit address pointer, modulo 2**ADDR_W, synchronous clear and
//   increment enable. Usable for both write-side and read-side scanning.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     clr        : force pointer to 0 (wins over inc)
//     inc        : advance pointer by one, wrapping after the last address
//     ptr        : current pointer value
//     last       : pointer is at the last address
module wr_ptr_counter #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              last
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr  = ptr_q;
  assign last = &ptr_q;

endmodule

// File: rtl/ram_seq_writer.sv
// ram_seq_writer
//   Appends handshaked words to consecutive RAM addresses and provides a
//   bulk clear that fills every address with CLEAR_VAL.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     clear_req  : one-cycle pulse starting a bulk clear (ignored while busy)
//     in_valid   : in_data holds a word to write
//     in_data    : word to write
//     in_ready   : word accepted this cycle when in_valid is also high
//     wr_addr    : registered RAM write address
//     wr_data    : registered RAM write data
//     wren       : registered RAM write enable
//     count      : number of valid words stored, saturating at 2**ADDR_W
//     full       : count == 2**ADDR_W
//     busy       : clear in progress
module ram_seq_writer
  import ram_writer_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned       DATA_W    = 4,
  parameter int unsigned       WRAP      = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wren,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wren_q, wren_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              busy_q, busy_d;

  logic              ptr_clr;
  logic              ptr_inc;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_last;

  wr_ptr_counter #(.ADDR_W(ADDR_W)) u_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (ptr_clr),
    .inc   (ptr_inc),
    .ptr   (ptr),
    .last  (ptr_last)
  );

  assign in_ready = (state_q == IDLE) && !clear_req && (!full_q || (WRAP != 0));

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wren_d    = 1'b0;
    count_d   = count_q;
    full_d    = full_q;
    busy_d    = busy_q;
    ptr_clr   = 1'b0;
    ptr_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          count_d = '0;
          full_d  = 1'b0;
          ptr_clr = 1'b1;
        end else if (in_valid && in_ready) begin
          wren_d    = 1'b1;
          wr_addr_d = ptr;
          wr_data_d = in_data;
          ptr_inc   = 1'b1;
          if (!full_q) begin
            count_d = count_q + 1'b1;
            full_d  = (count_q == DEPTH_C - 1'b1);
          end
        end
      end
      CLEAR: begin
        // Each CLEAR cycle issues one write; the write to the last address
        // is registered on the same edge that returns to IDLE, and the
        // pointer wraps back to 0 naturally.
        wren_d    = 1'b1;
        wr_addr_d = ptr;
        wr_data_d = CLEAR_VAL;
        ptr_inc   = 1'b1;
        if (ptr_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wren_q    <= 1'b0;
      count_q   <= '0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wren_q    <= wren_d;
      count_q   <= count_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wren    = wren_q;
  assign count   = count_q;
  assign full    = full_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ram_seq_writer.sv
// tb_ram_seq_writer
//   Two writers share one stimulus stream: index 0 stops when full with
//   CLEAR_VAL 0, index 1 wraps with CLEAR_VAL 4'hC. A word-level reference
//   model (count, next address, clear cycles remaining, memory image)
//   predicts every cycle's outputs.
module tb_ram_seq_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;

  logic [1:0] in_ready, wren, full, busy;
  logic [4:0] wr_addr [2];
  logic [3:0] wr_data [2];
  logic [5:0] count   [2];

  always #5 clk = ~clk;

  ram_seq_writer #(.ADDR_W(5), .DATA_W(4), .WRAP(0), .CLEAR_VAL(4'h0)) dut0 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .wren(wren[0]), .count(count[0]), .full(full[0]),
    .busy(busy[0])
  );

  ram_seq_writer #(.ADDR_W(5), .DATA_W(4), .WRAP(1), .CLEAR_VAL(4'hC)) dut1 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .wren(wren[1]), .count(count[1]), .full(full[1]),
    .busy(busy[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int         m_cnt  [2];
  int         m_ptr  [2];
  int         m_left [2];
  logic [3:0] m_mem  [2][32];
  logic [3:0] ram    [2][32];

  // {rdy, we, addr, data, count, full, busy}
  logic [18:0] exp_vec [2];
  logic [18:0] obs_vec [2];
  logic [1:0]  rdy_seen;

  // Drive one cycle (called at a negedge), advance the model, sample at the
  // next negedge.
  task automatic cyc(input logic v, input logic [3:0] d, input logic c, input logic r);
    logic       e_rdy, e_we;
    logic [4:0] e_a;
    logic [3:0] e_d;
    in_valid = v; in_data = d; clear_req = c; reset = r;
    #1;
    rdy_seen = in_ready;
    for (int i = 0; i < 2; i++) begin
      e_rdy = (m_left[i] == 0) && !c && (m_cnt[i] < 32 || i == 1);
      e_we = 1'b0; e_a = '0; e_d = '0;
      if (r) begin
        m_cnt[i] = 0; m_ptr[i] = 0; m_left[i] = 0;
      end else if (m_left[i] > 0) begin
        e_we = 1'b1; e_a = 5'(32 - m_left[i]); e_d = (i == 1) ? 4'hC : 4'h0;
        m_left[i]--;
      end else if (c) begin
        m_left[i] = 32; m_cnt[i] = 0; m_ptr[i] = 0;
      end else if (v && e_rdy) begin
        e_we = 1'b1; e_a = 5'(m_ptr[i]); e_d = d;
        m_ptr[i] = (m_ptr[i] + 1) % 32;
        if (m_cnt[i] < 32) m_cnt[i]++;
      end
      if (e_we) m_mem[i][e_a] = e_d;
      exp_vec[i] = {e_rdy, e_we, e_a, e_d, 6'(m_cnt[i]), m_cnt[i] == 32, m_left[i] > 0};
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      obs_vec[i] = {rdy_seen[i], wren[i], wren[i] ? wr_addr[i] : 5'd0,
                    wren[i] ? wr_data[i] : 4'd0, count[i], full[i], busy[i]};
      if (wren[i] === 1'b1) ram[i][wr_addr[i]] = wr_data[i];
    end
  endtask

  task automatic test_reset;
    cyc(0, 4'h0, 0, 1);
    cyc(0, 4'h0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(0, 4'h0, 0, 0);
    n_checks++;
    if ({wren[0], count[0], full[0], busy[0], in_ready[0], wr_addr[0], wr_data[0]} !==
        {1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0})
      $display("FAIL reset_state: wren=%b count=%0d full=%b busy=%b rdy=%b addr=%0d data=%h, required 0,0,0,0,1,0,0",
               wren[0], count[0], full[0], busy[0], in_ready[0], wr_addr[0], wr_data[0]);
    else n_pass++;
  endtask

  task automatic test_three_writes;
    logic [3:0] tbl [3];
    tbl[0] = 4'h1; tbl[1] = 4'hA; tbl[2] = 4'hF;
    for (int k = 0; k < 3; k++) begin
      cyc(1, tbl[k], 0, 0);
      n_checks++;
      if ({wren[0], wr_addr[0], wr_data[0]} !== {1'b1, 5'(k), tbl[k]})
        $display("FAIL three_writes[%0d]: wren=%b addr=%0d data=%h, required 1 %0d %h",
                 k, wren[0], wr_addr[0], wr_data[0], k, tbl[k]);
      else n_pass++;
    end
    cyc(0, 4'h0, 0, 0);
    n_checks++;
    if ({wren[0], count[0]} !== {1'b0, 6'd3})
      $display("FAIL three_writes_after: wren=%b count=%0d, required 0 3", wren[0], count[0]);
    else n_pass++;
  endtask

  task automatic test_fill;
    int acc = 0;
    int guard = 0;
    logic v;
    cyc(0, 4'h0, 0, 1);
    while (acc < 32 && guard < 200) begin
      v = ($urandom % 4) != 0;
      cyc(v, 4'(acc), 0, 0);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_vec[i] !== exp_vec[i])
          $display("FAIL fill_cycle dut%0d: got %h, required %h", i, obs_vec[i], exp_vec[i]);
        else n_pass++;
      end
      if (v) acc++;
      guard++;
    end
    n_checks++;
    if ({full[0], count[0], full[1], count[1]} !== {1'b1, 6'd32, 1'b1, 6'd32})
      $display("FAIL fill_full: full0=%b count0=%0d full1=%b count1=%0d, required 1 32 1 32",
               full[0], count[0], full[1], count[1]);
    else n_pass++;
    cyc(1, 4'h3, 0, 0);
    n_checks++;
    if ({rdy_seen[0], wren[0]} !== 2'b00)
      $display("FAIL fill_33_nowrap: ready=%b wren=%b, required 0 0", rdy_seen[0], wren[0]);
    else n_pass++;
    n_checks++;
    if ({wren[1], wr_addr[1], wr_data[1], count[1], full[1]} !== {1'b1, 5'd0, 4'h3, 6'd32, 1'b1})
      $display("FAIL fill_33_wrap: wren=%b addr=%0d data=%h count=%0d full=%b, required 1 0 3 32 1",
               wren[1], wr_addr[1], wr_data[1], count[1], full[1]);
    else n_pass++;
  endtask

  task automatic test_clear_collision;
    int busy_cycles = 0;
    cyc(0, 4'h0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 4'($urandom), 0, 0);
    cyc(1, 4'h7, 1, 0);
    n_checks++;
    if ({rdy_seen[0], wren[0], busy[0]} !== 3'b001)
      $display("FAIL clear_collide: ready=%b wren=%b busy=%b, required 0 0 1", rdy_seen[0], wren[0], busy[0]);
    else n_pass++;
    for (int k = 0; k < 32; k++) begin
      if (busy[0] === 1'b1) busy_cycles++;
      cyc(1, 4'h7, 0, 0);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_vec[i] !== exp_vec[i])
          $display("FAIL clear_cycle[%0d] dut%0d: got %h, required %h", k, i, obs_vec[i], exp_vec[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (busy_cycles != 32 || busy[0] !== 1'b0 || count[0] !== 6'd0)
      $display("FAIL clear_duration: busy_cycles=%0d busy=%b count=%0d, required 32 0 0",
               busy_cycles, busy[0], count[0]);
    else n_pass++;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 32; a++) begin
        n_checks++;
        if (ram[i][a] !== ((i == 1) ? 4'hC : 4'h0))
          $display("FAIL clear_content dut%0d addr %0d: got %h, required %h", i, a, ram[i][a],
                   (i == 1) ? 4'hC : 4'h0);
        else n_pass++;
      end
    cyc(1, 4'h7, 0, 0);
    n_checks++;
    if ({wren[0], wr_addr[0], wr_data[0], count[0]} !== {1'b1, 5'd0, 4'h7, 6'd1})
      $display("FAIL clear_then_write: wren=%b addr=%0d data=%h count=%0d, required 1 0 7 1",
               wren[0], wr_addr[0], wr_data[0], count[0]);
    else n_pass++;
    cyc(0, 4'h0, 0, 0);
  endtask

  task automatic test_reset_in_clear;
    bit found = 0;
    bit stray = 0;
    cyc(0, 4'h0, 1, 0);
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(0, 4'h0, 0, 0);
      if (wren[0] === 1'b1 && wr_addr[0] === 5'd9) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL reset_in_clear_reach: addr 9 write seen=0, required 1");
    else n_pass++;
    cyc(0, 4'h0, 0, 1);
    n_checks++;
    if ({wren[0], busy[0], wr_addr[0], count[0]} !== {1'b0, 1'b0, 5'd0, 6'd0})
      $display("FAIL reset_in_clear: wren=%b busy=%b addr=%0d count=%0d, required 0 0 0 0",
               wren[0], busy[0], wr_addr[0], count[0]);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 4'h0, 0, 0);
      if (wren !== 2'b00) stray = 1;
    end
    n_checks++;
    if (stray) $display("FAIL reset_in_clear_stray: write seen after reset=1, required 0");
    else n_pass++;
  endtask

  task automatic test_double_clear;
    int busy_cycles = 0;
    cyc(0, 4'h0, 1, 0);
    for (int k = 0; k < 40; k++) begin
      if (busy[0] === 1'b1) busy_cycles++;
      cyc(0, 4'h0, k == 5, 0);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_vec[i] !== exp_vec[i])
          $display("FAIL double_clear[%0d] dut%0d: got %h, required %h", k, i, obs_vec[i], exp_vec[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (busy_cycles != 32)
      $display("FAIL double_clear_duration: busy_cycles=%0d, required 32", busy_cycles);
    else n_pass++;
  endtask

  task automatic test_random;
    logic v, c, r;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom % 3) != 0;
      c = ($urandom % 60) == 0;
      r = ($urandom % 250) == 0;
      cyc(v, 4'($urandom), c, r);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_vec[i] !== exp_vec[i])
          $display("FAIL random[%0d] dut%0d: got %h, required %h", k, i, obs_vec[i], exp_vec[i]);
        else n_pass++;
      end
    end
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 32; a++) begin
        n_checks++;
        if (ram[i][a] !== m_mem[i][a])
          $display("FAIL random_mem dut%0d addr %0d: got %h, required %h", i, a, ram[i][a], m_mem[i][a]);
        else n_pass++;
      end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_ptr[i] = 0; m_left[i] = 0;
      for (int a = 0; a < 32; a++) begin
        m_mem[i][a] = '0;
        ram[i][a]   = '0;
      end
    end
    test_reset();
    test_three_writes();
    test_fill();
    test_clear_collision();
    test_reset_in_clear();
    test_double_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_seq_writer.md
Name: ram_seq_writer

Overview:
- Write-side companion to the scanning read counter on the 32x4 dual-port RAM.
- Accepts 4-bit words over a valid/ready handshake and writes them to consecutive RAM addresses. It drives the RAM write port (wraddress, data, wren) while an independent reader scans rdaddress.
- Also provides a bulk clear that fills every address with a constant.
- Sits between the switch/KEY input logic and the RAM write port.

Parameters:
- ADDR_W, 5, RAM address width; depth = 2**ADDR_W.
- DATA_W, 4, RAM word width.
- WRAP, 0, 1 = pointer wraps after the last address and writing continues; 0 = stop when full.
- CLEAR_VAL, 0, word written to every address during a clear.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clear_req  input  1  one-cycle pulse that starts a bulk clear.
- in_valid  input  1  in_data holds a word to write.
- in_data  input  DATA_W  word to write.
- in_ready  output  1  block accepts in_data this cycle.
- wr_addr  output  ADDR_W  RAM write address (registered).
- wr_data  output  DATA_W  RAM write data (registered).
- wren  output  1  RAM write enable (registered).
- count  output  ADDR_W+1  number of valid words stored, 0..2**ADDR_W.
- full  output  1  count == 2**ADDR_W.
- busy  output  1  clear in progress.

Behaviour:
- Reset values: wr_addr=0, wr_data=0, wren=0, count=0, full=0, busy=0; internal pointer=0; state=IDLE.
- States: IDLE (normal append) and CLEAR.
- in_ready = (state==IDLE) && !clear_req && (!full || WRAP).
- A handshake occurs when in_valid && in_ready at a rising edge. Next cycle: wren=1, wr_addr=pointer, wr_data=in_data. The pointer increments in the same edge. Write latency is 1 cycle.
- wren=0 in any cycle following a non-handshake IDLE cycle.
- Back-to-back handshakes produce one write per cycle with consecutive addresses.
- Pointer arithmetic is modulo 2**ADDR_W; the last address (31) is followed by 0.
- count increments on each handshake and saturates at 2**ADDR_W. In WRAP=1, writes past full overwrite the oldest data; count stays 32 and full stays 1.
- WRAP=0 and full: in_ready=0, and in_valid is ignored with no write.
- clear_req in IDLE: state moves to CLEAR; busy=1 from the next cycle. The pointer and count are reset to 0 on entry.
  - CLEAR issues 2**ADDR_W writes, one per cycle, with wr_addr 0..31, wr_data=CLEAR_VAL, wren=1.
  - After the write to address 31: state returns to IDLE, busy=0, count=0, full=0, pointer=0.
  - Total busy duration is exactly 2**ADDR_W cycles.
- clear_req and in_valid in the same cycle: clear wins. in_ready is 0 so the word is not accepted; the source must hold it.
- clear_req while already in CLEAR: ignored; the clear does not restart.
- reset during CLEAR: the clear is abandoned. All outputs take reset values on the next edge and no further writes are issued.
- reset overrides clear_req and in_valid in the same cycle.
- No combinational path from in_data to any output. in_ready depends only on state, full and clear_req.

Decomposition:
- Package ram_writer_pkg: state enum (IDLE, CLEAR) and localparam DEPTH = 2**ADDR_W default.
- One natural sub-module, wr_ptr_counter:
  - ADDR_W-bit pointer with synchronous clear, increment enable and wrap.
  - Shared by append and clear modes.
  - Also reusable as the read-side scan counter.

Test Plan:
- Reset then idle 5 cycles -> wren=0, count=0, full=0, busy=0, in_ready=1, wr_addr=0.
- Three consecutive handshakes of 4'h1, 4'hA, 4'hF -> on the following cycles wren=1 with (addr,data) = (0,1), (1,A), (2,F); then count=3 and wren=0.
- WRAP=0: 32 handshakes of data=addr[3:0] -> full=1 and count=32 after the 32nd. A 33rd in_valid sees in_ready=0 and no write occurs. WRAP=1: the 33rd writes addr 0 and count stays 32.
- After 5 writes, pulse clear_req in the same cycle as in_valid=1 with 4'h7 -> word not accepted. busy=1 for 32 cycles with writes to addr 0..31 of CLEAR_VAL; afterwards count=0. The next handshake with 4'h7 writes addr 0.
- Assert reset at clear cycle 10 (addr 9 written) -> next cycle wren=0, busy=0, wr_addr=0, count=0. No write to addr 10 occurs.
- Second clear_req during CLEAR -> ignored; busy deasserts exactly 32 cycles after the first pulse.
